// File: rtl/mac_operand_fifo_if.sv
// -----------------------------------------------------------------------------
// mac_operand_fifo_if
//   Push and pop handshake bundle for the MAC operand buffer.
//
//   in_valid  : producer -> buffer, push request
//   in_ready  : buffer -> producer, push accepted when in_valid & in_ready
//   in_data   : producer -> buffer, operand to push
//   out_valid : buffer -> consumer, head entry available
//   out_ready : consumer -> buffer, pop accepted when out_valid & out_ready
//   out_data  : buffer -> consumer, head entry
//
//   Modports:
//     master : the side that drives pushes and takes pops (producer/consumer)
//     slave  : the buffer itself
// -----------------------------------------------------------------------------
interface mac_operand_fifo_if #(
    parameter int DataWidth = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [DataWidth-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [DataWidth-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/mac_operand_fifo.sv
// -----------------------------------------------------------------------------
// mac_operand_fifo
//   Four-entry circular operand buffer feeding the MAC ready-mask stage.
//   The write pointer, read pointer and lap bit (Round) are exported because
//   the ready-mask stage derives per-entry readiness from exactly these three
//   signals; count is kept equal to the distance that stage computes.
//
//   Ports:
//     clk     : clock, all state updates on the rising edge
//     rst_n   : synchronous active-low reset of pointers, Round and count
//     flush   : synchronous clear of pointers, Round and count
//     bus     : push/pop handshake bundle (slave side)
//     W_Addr  : next slot to be written
//     R_Addr  : slot currently at the head
//     Round   : write pointer is one lap ahead of the read pointer
//     count   : occupancy, 0..BufferSize
// -----------------------------------------------------------------------------
module mac_operand_fifo #(
    parameter int DataWidth   = 16,
    parameter int BufferWidth = 2,
    parameter int BufferSize  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    mac_operand_fifo_if.slave      bus,
    output logic [BufferWidth-1:0] W_Addr,
    output logic [BufferWidth-1:0] R_Addr,
    output logic                   Round,
    output logic [BufferWidth:0]   count
);

    localparam logic [BufferWidth-1:0] LastSlot = BufferWidth'(BufferSize - 1);
    localparam logic [BufferWidth-1:0] PtrOne   = BufferWidth'(1);
    localparam logic [BufferWidth:0]   CntOne   = (BufferWidth + 1)'(1);

    logic [DataWidth-1:0] mem [BufferSize];

    logic [BufferWidth-1:0] w_addr_q;
    logic [BufferWidth-1:0] r_addr_q;
    logic                   round_q;
    logic [BufferWidth:0]   count_q;

    logic same_slot;
    logic empty;
    logic full;
    logic push;
    logic pop;
    logic w_wrap;
    logic r_wrap;

    // Equal pointers are disambiguated by the lap bit: same lap means empty,
    // one lap apart means full.
    assign same_slot = (w_addr_q == r_addr_q);
    assign empty     = same_slot & ~round_q;
    assign full      = same_slot &  round_q;

    // rst_n gates the handshakes combinationally so nothing is offered or
    // accepted while reset is held, independent of register state.
    assign bus.in_ready  = ~full  & rst_n;
    assign bus.out_valid = ~empty & rst_n;
    assign bus.out_data  = mem[r_addr_q];

    assign push = bus.in_valid  & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    assign w_wrap = push & (w_addr_q == LastSlot);
    assign r_wrap = pop  & (r_addr_q == LastSlot);

    // Control state: pointers, lap bit and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_addr_q <= '0;
            r_addr_q <= '0;
            round_q  <= 1'b0;
            count_q  <= '0;
        end else if (flush) begin
            w_addr_q <= '0;
            r_addr_q <= '0;
            round_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            if (push) begin
                w_addr_q <= w_addr_q + PtrOne;
            end
            if (pop) begin
                r_addr_q <= r_addr_q + PtrOne;
            end
            // A lone wrap moves the lap relationship; two wraps cancel.
            round_q <= round_q ^ (w_wrap ^ r_wrap);
            case ({push, pop})
                2'b10:   count_q <= count_q + CntOne;
                2'b01:   count_q <= count_q - CntOne;
                default: count_q <= count_q;
            endcase
        end
    end

    // Operand storage is never cleared; out_valid keeps stale slots hidden.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && push) begin
            mem[w_addr_q] <= bus.in_data;
        end
    end

    assign W_Addr = w_addr_q;
    assign R_Addr = r_addr_q;
    assign Round  = round_q;
    assign count  = count_q;

endmodule

// File: doc/mac_operand_fifo.md
# mac_operand_fifo

Four-entry circular operand buffer that sits directly upstream of the MAC ready-mask logic. It accepts operands through a valid/ready push port and releases them through a valid/ready pop port. It exports the write pointer, read pointer and lap (Round) bit. The ready-mask stage uses these three signals to derive per-entry readiness, so their encoding is contractual.

## Interface
- DataWidth, 16, operand width in bits
- BufferWidth, 2, pointer width; must equal log2(BufferSize)
- BufferSize, 4, number of entries
- clk  input  1  clock; all state updates on its rising edge
- rst_n  input  1  reset, synchronous, active-low
- flush  input  1  synchronous clear of pointers/Round/count; storage contents untouched
- in_valid  input  1  push request
- in_ready  output  1  push accepted when in_valid & in_ready
- in_data  input  DataWidth  operand to push
- out_valid  output  1  head entry available
- out_ready  input  1  pop accepted when out_valid & out_ready
- out_data  output  DataWidth  head entry, mem[R_Addr]
- W_Addr  output  BufferWidth  next slot to be written
- R_Addr  output  BufferWidth  slot currently at head
- Round  output  1  1 when the write pointer is one lap ahead of the read pointer
- count  output  BufferWidth+1  occupancy, 0..BufferSize

## Operation
- Storage: BufferSize x DataWidth register array, written only on push. No reset of contents.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- On push: mem[W_Addr] <= in_data; W_Addr <= W_Addr+1, wrapping modulo BufferSize.
- On pop: R_Addr <= R_Addr+1, wrapping modulo BufferSize.
- Round toggles when exactly one of the following occurs in a cycle:
  - a push wraps W_Addr from BufferSize-1 to 0;
  - a pop wraps R_Addr from BufferSize-1 to 0.
- If both wraps occur in the same cycle, Round is unchanged.
- Invariant: count == (Round ? W_Addr+BufferSize : W_Addr) - R_Addr, computed at BufferWidth+1 bits. This is the distance the ready-mask stage computes; count must never disagree with it.
- empty = (W_Addr==R_Addr) & ~Round. full = (W_Addr==R_Addr) & Round.
- in_ready = ~full & rst_n. It does not depend on out_ready, so no push is accepted into a full buffer even when a pop occurs in the same cycle.
- out_valid = ~empty & rst_n. out_data is a combinational read of mem[R_Addr]. Write-through from in_data is not provided.
- Simultaneous push and pop, neither full nor empty: both pointers advance, count unchanged, Round follows the wrap rule above.
- Priority: rst_n low over flush over push/pop. During flush, push and pop are ignored even if handshakes are asserted.
- No state machine beyond the pointer/Round registers. count is a register kept consistent with the invariant and is not recomputed combinationally.

## Timing
- Reset values: W_Addr=0, R_Addr=0, Round=0, count=0. While rst_n is low, in_ready=0 and out_valid=0. out_data is undefined (X permitted) until the first push.
- First cycle with rst_n high: in_ready=1, out_valid=0.
- Latency: an entry pushed at edge N is visible (out_valid=1, out_data valid) in the cycle after edge N. Minimum push-to-pop latency is 1 cycle.
- Throughput: one push and one pop per cycle sustained.
- Status outputs change only on clk edges: W_Addr, R_Addr, Round, count, and out_valid/in_ready (apart from rst_n gating).
- Reset or flush asserted mid-stream: at the next edge the buffer returns to its empty reset state, and any handshake in that cycle is discarded. Stale storage is never presented because out_valid=0.

## Test plan
- Reset then idle: rst_n low 3 cycles, then high. Required: W_Addr=0, R_Addr=0, Round=0, count=0, in_ready=1, out_valid=0.
- Fill to full: push 0xA0..0xA3 with out_ready=0. Required:
  - after the 4th push: W_Addr=0, R_Addr=0, Round=1, count=4, in_ready=0;
  - a 5th in_valid is ignored.
- Drain with wrap: from the full state, pop 4 times. Required: out_data sequence 0xA0,0xA1,0xA2,0xA3; then R_Addr=0, Round=0, count=0, out_valid=0.
- Round invariant and simultaneous push/pop:
  - Setup: push 3 entries.
  - Stimulus: 10 cycles of simultaneous push and pop with incrementing data.
  - Required: count=3 throughout, data in order; Round=1 exactly when W_Addr<R_Addr.
  - Check: (Round?W_Addr+4:W_Addr)-R_Addr==count on every cycle.
- Flush mid-stream: flush with 2 entries held (W_Addr=3, R_Addr=1) while in_valid=1 and out_ready=1. Required:
  - next cycle all pointers/Round/count are 0 and out_valid=0;
  - the in_data presented in the flush cycle is never output.
- Reset priority: assert rst_n low and flush together with push pending. Required: reset state, in_ready=0 while rst_n is low.
